// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch/issue unit: owns the PC, fetches 16-bit words over a
// req/ready/valid handshake, issues opcode/operand to ControlUnit, and stops on HALT.
module instr_fetch_unit #(
  parameter int PC_WIDTH = 8,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imemReq,
  output logic [PC_WIDTH-1:0] imemAddr,
  input  logic                imemReady,
  input  logic                imemValid,
  input  logic [15:0]         imemData,
  output logic [3:0]          opcode,
  output logic [11:0]         operand,
  output logic                instrValid,
  input  logic                stall,
  input  logic                jump,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic [15:0]         instrCount,
  output logic [2:0]          dbgState
);

  // Handshake: a fetch is accepted on an edge where imemReq && imemReady (REQ only);
  // the response is taken on an edge where imemValid is high while in WAIT only, so a
  // valid coinciding with acceptance, or arriving outside WAIT, is dropped.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [11:0]         operand_q, operand_d;
  logic [15:0]         count_q, count_d;
  logic                halted_q, halted_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_WIDTH'(RESET_PC);
      opcode_q  <= 4'd0;
      operand_q <= 12'd0;
      count_q   <= 16'd0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      count_q   <= count_d;
      halted_q  <= halted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    count_d   = count_q;
    halted_d  = halted_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imemReady) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imemValid) begin
          opcode_d  = imemData[15:12];
          operand_d = imemData[11:0];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          count_d = count_q + 16'd1;
          // HALT takes priority over a jump: the PC stays on the HALT word.
          if (opcode_q == OP_HALT) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_d    = jump ? operand_q[PC_WIDTH-1:0] : pc_q + PC_WIDTH'(1);
            state_d = S_REQ;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign imemReq    = (state_q == S_REQ);
  assign imemAddr   = pc_q;
  assign instrValid = (state_q == S_ISSUE);
  assign opcode     = opcode_q;
  assign operand    = operand_q;
  assign pc         = pc_q;
  assign halted     = halted_q;
  assign instrCount = count_q;
  assign dbgState   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed and randomized fetch/issue sequences checked
// against a program-level model of PC, retire count and HALT behaviour.
module tb_instr_fetch_unit;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imemReady = 1'b0;
  logic          imemValid = 1'b0;
  logic [15:0]   imemData = 16'h0;
  logic          stall = 1'b0;
  logic          jump = 1'b0;
  logic          imemReq;
  logic [PW-1:0] imemAddr;
  logic [3:0]    opcode;
  logic [11:0]   operand;
  logic          instrValid;
  logic [PW-1:0] pc;
  logic          halted;
  logic [15:0]   instrCount;
  logic [2:0]    dbgState;

  instr_fetch_unit #(.PC_WIDTH(PW), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady),
    .imemValid(imemValid), .imemData(imemData),
    .opcode(opcode), .operand(operand), .instrValid(instrValid),
    .stall(stall), .jump(jump), .pc(pc), .halted(halted),
    .instrCount(instrCount), .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  int base_edge = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  // Reference model: architectural view of the program
  logic [PW-1:0] m_pc;
  logic [15:0]   m_cnt;
  logic          m_halted;
  logic [3:0]    m_op;
  logic [11:0]   m_operand;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_cnt = 16'd0; m_halted = 1'b0; m_op = 4'd0; m_operand = 12'd0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_opcode"}, opcode, 0);
    chk({tag, "_operand"}, operand, 0);
    chk({tag, "_valid"}, instrValid, 0);
    chk({tag, "_req"}, imemReq, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_count"}, instrCount, 0);
  endtask

  // Reset held over one edge; returns at the negedge right after release is set up.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imemReady = 1'b0; imemValid = 1'b0; stall = 1'b0; jump = 1'b0;
    @(negedge clk);
    check_reset_values("rst");
    model_reset();
    rst_n = 1'b1;
    base_edge = edge_cnt;
  endtask

  // Serve one fetch: ready held low nready cycles, valid nvalid cycles after acceptance.
  task automatic serve_fetch(input logic [15:0] word, input int nready, input int nvalid,
                             input bit spur);
    int n;
    n = 0;
    while (!imemReq && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_timeout", imemReq, 1);
    if (!imemReq) return;
    chk("req_addr", imemAddr, m_pc);
    for (int i = 0; i < nready; i++) begin
      imemReady = 1'b0;
      imemValid = spur && (i == 0);
      imemData  = 16'hDEAD;
      @(negedge clk);
      imemValid = 1'b0;
      chk("req_held", imemReq, 1);
      chk("addr_held", imemAddr, m_pc);
      chk("no_valid_in_req", instrValid, 0);
    end
    imemReady = 1'b1;
    imemValid = spur;
    imemData  = 16'hBEEF;
    @(negedge clk);
    imemReady = 1'b0;
    imemValid = 1'b0;
    chk("req_dropped", imemReq, 0);
    chk("no_capture_on_accept", instrValid, 0);
    chk("opcode_kept", opcode, m_op);
    for (int i = 0; i < nvalid; i++) begin
      @(negedge clk);
      chk("wait_no_valid", instrValid, 0);
      chk("wait_no_req", imemReq, 0);
    end
    imemValid = 1'b1;
    imemData  = word;
    @(negedge clk);
    imemValid = 1'b0;
    imemData  = 16'h0;
    m_op = word[15:12];
    m_operand = word[11:0];
    chk("issue_valid", instrValid, 1);
    chk("issue_opcode", opcode, m_op);
    chk("issue_operand", operand, m_operand);
    chk("issue_pc", pc, m_pc);
  endtask

  // Hold stall for nstall cycles, then retire with the given jump decision.
  task automatic retire(input bit jump_v, input int nstall);
    for (int i = 0; i < nstall; i++) begin
      stall = 1'b1;
      jump  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stall_valid", instrValid, 1);
      chk("stall_opcode", opcode, m_op);
      chk("stall_operand", operand, m_operand);
      chk("stall_pc", pc, m_pc);
      chk("stall_count", instrCount, m_cnt);
      chk("stall_no_req", imemReq, 0);
    end
    stall = 1'b0;
    jump  = jump_v;
    @(negedge clk);
    jump = 1'b0;
    m_cnt = m_cnt + 16'd1;
    if (m_op == 4'hF) m_halted = 1'b1;
    else if (jump_v) m_pc = m_operand[PW-1:0];
    else m_pc = PW'((int'(m_pc) + 1) % (1 << PW));
    chk("retire_pc", pc, m_pc);
    chk("retire_count", instrCount, m_cnt);
    chk("retire_halted", halted, m_halted);
    chk("retire_valid", instrValid, 0);
    chk("retire_req", imemReq, !m_halted);
  endtask

  task automatic halt_hold(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      chk("halt_halted", halted, 1);
      chk("halt_no_req", imemReq, 0);
      chk("halt_no_valid", instrValid, 0);
      chk("halt_pc", pc, m_pc);
      chk("halt_count", instrCount, m_cnt);
    end
  endtask

  logic [15:0] seq_prog[4];
  logic [15:0] w;

  initial begin
    seq_prog[0] = 16'h0123; seq_prog[1] = 16'h1456;
    seq_prog[2] = 16'h2789; seq_prog[3] = 16'hF000;

    // Sequential fetch with zero-wait memory, ending in HALT
    do_reset();
    @(negedge clk);
    chk("first_req_cycle", edge_cnt - base_edge, 1);
    for (int i = 0; i < 4; i++) begin
      serve_fetch(seq_prog[i], 0, 0, 1'b0);
      chk("issue_cycle", edge_cnt - base_edge, 3 * (i + 1));
      retire(1'b0, 0);
    end
    chk("seq_count", instrCount, 4);
    halt_hold(5);

    // Jump redirect, then PC wrap from all-ones
    do_reset();
    serve_fetch(16'h4010, 0, 0, 1'b0);
    retire(1'b1, 0);
    chk("jump_addr", imemAddr, 8'h10);
    serve_fetch(16'h40FF, 0, 0, 1'b0);
    retire(1'b1, 0);
    serve_fetch(16'h1234, 0, 0, 1'b0);
    retire(1'b0, 0);
    chk("wrap_addr", imemAddr, 8'h00);

    // Handshake stress and stall
    serve_fetch(16'h2ABC, 3, 2, 1'b1);
    retire(1'b0, 4);

    // Randomized program
    for (int i = 0; i < 30; i++) begin
      w = {4'($urandom_range(0, 14)), 12'($urandom_range(0, 4095))};
      serve_fetch(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      retire(1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Reset while in WAIT; stale response must be dropped
    while (!imemReq) @(negedge clk);
    imemReady = 1'b1;
    @(negedge clk);
    imemReady = 1'b0;
    chk("midrst_in_wait", imemReq, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    model_reset();
    rst_n = 1'b1;
    base_edge = edge_cnt;
    imemValid = 1'b1;
    imemData  = 16'h5555;
    @(negedge clk);
    imemValid = 1'b0;
    chk("stale_not_issued", instrValid, 0);
    chk("stale_opcode", opcode, 0);
    chk("fresh_req", imemReq, 1);
    chk("fresh_addr", imemAddr, 0);
    serve_fetch(16'h3ABC, 0, 0, 1'b0);
    retire(1'b0, 0);

    // HALT with jump forced high
    serve_fetch(16'hF0AA, 1, 1, 1'b0);
    retire(1'b1, 0);
    chk("halt_jump_pc", pc, 8'h01);
    halt_hold(20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
